// File: rtl/keypad_scanner_fifo.sv
// Matrix keypad scanner: column drive, per-frame lowest-code detection,
// press/release debounce FSM, and a small FIFO of accepted key codes.
module keypad_scanner_fifo #(
   parameter int N_ROWS     = 4,
   parameter int N_COLS     = 4,
   parameter int SCAN_DIV   = 27000,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int KW        = $clog2(N_ROWS * N_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_ROWS-1:0] row_in,
   output logic [N_COLS-1:0] col_out,
   output logic [KW-1:0]     key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_held,
   output logic              overflow
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int NW = $clog2(DEBOUNCE + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PRESSED,
      S_RELEASE
   } state_t;

   logic [DW-1:0] div_cnt;
   logic [CW-1:0] col_idx;
   logic          sample_tick;
   logic          frame_end;

   assign sample_tick = (div_cnt == DW'(SCAN_DIV - 1));
   assign frame_end   = sample_tick && (col_idx == CW'(N_COLS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         col_idx <= '0;
      end else if (sample_tick) begin
         div_cnt <= '0;
         col_idx <= (col_idx == CW'(N_COLS - 1)) ? '0 : col_idx + CW'(1);
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   always_comb begin
      col_out          = '0;
      col_out[col_idx] = 1'b1;
   end

   logic          row_hit;
   logic [RW-1:0] row_sel;
   logic [KW-1:0] sample_code;

   // NOTE: every always_comb output gets a default before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      row_hit = 1'b0;
      row_sel = '0;
      for (int r = N_ROWS - 1; r >= 0; r--) begin
         if (row_in[r]) begin
            row_hit = 1'b1;
            row_sel = RW'(r);
         end
      end
   end

   assign sample_code = KW'(int'(row_sel) * N_COLS + int'(col_idx));

   // Running minimum over the frame; res_* folds in the current column's sample.
   logic          acc_hit;
   logic [KW-1:0] acc_code;
   logic          res_hit;
   logic [KW-1:0] res_code;

   always_comb begin
      res_hit  = acc_hit;
      res_code = acc_code;
      if (row_hit && (!acc_hit || (sample_code < acc_code))) begin
         res_hit  = 1'b1;
         res_code = sample_code;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_hit  <= 1'b0;
         acc_code <= '0;
      end else if (frame_end) begin
         acc_hit  <= 1'b0;
         acc_code <= '0;
      end else if (sample_tick) begin
         acc_hit  <= res_hit;
         acc_code <= res_code;
      end
   end

   state_t        state_q, state_d;
   logic [NW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] cand_q, cand_d;
   logic [NW-1:0] cnt_inc;
   logic          match;
   logic          push;

   assign cnt_inc = cnt_q + NW'(1);
   assign match   = res_hit && (res_code == cand_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      push    = 1'b0;
      if (frame_end) begin
         unique case (state_q)
            S_IDLE: begin
               if (res_hit) begin
                  state_d = S_DEBOUNCE;
                  cand_d  = res_code;
                  cnt_d   = NW'(1);
               end
            end
            S_DEBOUNCE: begin
               if (!res_hit) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (match) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= NW'(DEBOUNCE)) begin
                     push    = 1'b1;
                     state_d = S_PRESSED;
                  end
               end else begin
                  cand_d = res_code;
                  cnt_d  = NW'(1);
               end
            end
            S_PRESSED: begin
               if (!match) begin
                  state_d = S_RELEASE;
                  cnt_d   = NW'(1);
               end
            end
            S_RELEASE: begin
               if (match) begin
                  state_d = S_PRESSED;
               end else if (cnt_inc >= NW'(DEBOUNCE)) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign key_held = (state_q == S_PRESSED) || (state_q == S_RELEASE);

   logic [KW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok, drop;

   assign full      = (count == (AW + 1)'(FIFO_DEPTH));
   assign key_valid = (count != '0);
   assign pop       = key_valid && key_ready;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign push_ok   = push && (!full || pop);
   assign drop      = push && full && !pop;
   assign key_code  = key_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW + 1)'(1);
         else if (pop && !push_ok) count <= count - (AW + 1)'(1);
         if (drop) overflow <= 1'b1;
      end
   end

   // NOTE: storage is deliberately left unreset; occupancy is tracked by the
   // pointers/count and key_code is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= cand_q;
   end

endmodule
